// File: rtl/cpu_stage_ctrl.sv
// rtl/cpu_stage_ctrl.sv - multicycle IF/ID/EX/MA/WB sequencer for the RV32I core
// Optional active-cycle counter enabled by defining STAGE_CTRL_PERF_CNT_EN.
module cpu_stage_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             imem_valid,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_halt,
  input  logic             reg_we,
  input  logic             mem_ack,
  output logic             fetch_en,
  output logic             ir_we,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_req,
  output logic             mem_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MA   = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_ERR  = 3'd7
  } state_e;

  // Counter only needs to reach MEM_TIMEOUT-1; it wraps harmlessly when the timeout is off.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = TIMEOUT_EN ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    fetch_en  = 1'b0;
    ir_we     = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    halted    = 1'b0;
    err       = 1'b0;
    busy      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_IF;
      end
      S_IF: begin
        busy     = 1'b1;
        fetch_en = 1'b1;
        if (imem_valid) begin
          ir_we   = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        busy      = 1'b1;
        decode_en = 1'b1;
        state_d   = S_EX;
      end
      S_EX: begin
        busy    = 1'b1;
        exec_en = 1'b1;
        if (is_halt)                 state_d = S_HALT;
        else if (is_load || is_store) state_d = S_MA;
        else                          state_d = S_WB;
      end
      S_MA: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = is_store;
        // A late ack on the final allowed cycle still completes the access.
        if (mem_ack) begin
          wait_d  = '0;
          state_d = S_WB;
        end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
          wait_d  = '0;
          state_d = S_ERR;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        busy      = 1'b1;
        pc_we     = 1'b1;
        rf_we     = reg_we & ~is_store;
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_IF;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  assign state_out = state_q;
  assign retired   = retired_q;

`ifdef STAGE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
    end else if (busy) begin
      cycle_q <= cycle_q + CNT_W'(1);
    end
  end

  assign cycle_count = cycle_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_stage_ctrl.sv
// tb/tb_cpu_stage_ctrl.sv - directed-vector bench for cpu_stage_ctrl
module tb_cpu_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, imem_valid = 1'b0;
  logic        is_load = 1'b0, is_store = 1'b0, is_halt = 1'b0, reg_we = 1'b0;
  logic        mem_ack = 1'b0;
  logic        fetch_en, ir_we, decode_en, exec_en, mem_req, mem_we, rf_we, pc_we;
  logic        busy, halted, err;
  logic [2:0]  state_out;
  logic [31:0] retired, cycle_count;
  logic [7:0]  strb;

  int n_total = 0;
  int n_bad   = 0;

  // {fetch_en, ir_we, decode_en, exec_en, mem_req, mem_we, rf_we, pc_we}
  localparam logic [7:0] V_NONE  = 8'h00;
  localparam logic [7:0] V_IFW   = 8'h80;
  localparam logic [7:0] V_IF    = 8'hC0;
  localparam logic [7:0] V_ID    = 8'h20;
  localparam logic [7:0] V_EX    = 8'h10;
  localparam logic [7:0] V_LD    = 8'h08;
  localparam logic [7:0] V_ST    = 8'h0C;
  localparam logic [7:0] V_WB_RF = 8'h03;
  localparam logic [7:0] V_WB    = 8'h01;

  cpu_stage_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_valid(imem_valid),
    .is_load(is_load), .is_store(is_store), .is_halt(is_halt), .reg_we(reg_we),
    .mem_ack(mem_ack), .fetch_en(fetch_en), .ir_we(ir_we), .decode_en(decode_en),
    .exec_en(exec_en), .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we),
    .pc_we(pc_we), .busy(busy), .halted(halted), .err(err),
    .state_out(state_out), .retired(retired), .cycle_count(cycle_count)
  );

  assign strb = {fetch_en, ir_we, decode_en, exec_en, mem_req, mem_we, rf_we, pc_we};

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] s);
    @(negedge clk);
    #1;
    expect_eq({tag, ".state"}, 32'(state_out), 32'(st));
    expect_eq({tag, ".strb"}, 32'(strb), 32'(s));
    expect_eq({tag, ".busy"}, 32'(busy), 32'(st >= 3'd1 && st <= 3'd5));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0; imem_valid = 1'b0; mem_ack = 1'b0;
    is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0; reg_we = 1'b0;
    #1;
    expect_eq({tag, ".rst_state"}, 32'(state_out), 32'd0);
    expect_eq({tag, ".rst_strb"}, 32'(strb), 32'd0);
    expect_eq({tag, ".rst_flags"}, 32'({busy, halted, err}), 32'd0);
    expect_eq({tag, ".rst_ret"}, retired, 32'd0);
    expect_eq({tag, ".rst_cyc"}, cycle_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ADDI, zero-wait fetch
    do_reset("addi");
    start = 1'b1; imem_valid = 1'b1; reg_we = 1'b1;
    cyc("addi.if", 3'd1, V_IF);
    start = 1'b0;
    cyc("addi.id", 3'd2, V_ID);
    cyc("addi.ex", 3'd3, V_EX);
    cyc("addi.wb", 3'd5, V_WB_RF);
    cyc("addi.if2", 3'd1, V_IF);
    expect_eq("addi.retired", retired, 32'd1);

    // LW, ack on the 4th MA cycle (also the timeout boundary for MEM_TIMEOUT=4)
    do_reset("lw");
    start = 1'b1; imem_valid = 1'b1; is_load = 1'b1; reg_we = 1'b1;
    cyc("lw.if", 3'd1, V_IF);
    start = 1'b0;
    cyc("lw.id", 3'd2, V_ID);
    cyc("lw.ex", 3'd3, V_EX);
    for (int i = 0; i < 4; i++) cyc("lw.ma", 3'd4, V_LD);
    mem_ack = 1'b1;
    cyc("lw.wb", 3'd5, V_WB_RF);
    mem_ack = 1'b0;
    cyc("lw.if2", 3'd1, V_IF);
    expect_eq("lw.retired", retired, 32'd1);
    expect_eq("lw.err", 32'(err), 32'd0);
`ifdef STAGE_CTRL_PERF_CNT_EN
    expect_eq("lw.cycles", cycle_count, 32'd8);
`else
    expect_eq("lw.cycles", cycle_count, 32'd0);
`endif

    // SW with one imem stall and immediate ack
    do_reset("sw");
    start = 1'b1; is_store = 1'b1; reg_we = 1'b1;
    cyc("sw.ifw", 3'd1, V_IFW);
    start = 1'b0; imem_valid = 1'b1;
    cyc("sw.id", 3'd2, V_ID);
    cyc("sw.ex", 3'd3, V_EX);
    cyc("sw.ma", 3'd4, V_ST);
    mem_ack = 1'b1;
    cyc("sw.wb", 3'd5, V_WB);
    mem_ack = 1'b0;
    cyc("sw.if2", 3'd1, V_IF);
    expect_eq("sw.retired", retired, 32'd1);

    // Load with no ack: trap after 4 MA cycles
    do_reset("to");
    start = 1'b1; imem_valid = 1'b1; is_load = 1'b1; reg_we = 1'b1;
    cyc("to.if", 3'd1, V_IF);
    start = 1'b0;
    cyc("to.id", 3'd2, V_ID);
    cyc("to.ex", 3'd3, V_EX);
    for (int i = 0; i < 4; i++) cyc("to.ma", 3'd4, V_LD);
    cyc("to.err", 3'd7, V_NONE);
    expect_eq("to.err_flag", 32'(err), 32'd1);
    expect_eq("to.retired", retired, 32'd0);
    start = 1'b1;
    cyc("to.err2", 3'd7, V_NONE);
    start = 1'b0;
    cyc("to.err3", 3'd7, V_NONE);
    expect_eq("to.err_sticky", 32'(err), 32'd1);

    // Reset asserted mid-MA drops everything before the next edge
    do_reset("mid");
    start = 1'b1; imem_valid = 1'b1; is_store = 1'b1; reg_we = 1'b1;
    cyc("mid.if", 3'd1, V_IF);
    start = 1'b0;
    cyc("mid.id", 3'd2, V_ID);
    cyc("mid.ex", 3'd3, V_EX);
    cyc("mid.ma", 3'd4, V_ST);
    #1;
    rst = 1'b0;
    #1;
    expect_eq("mid.state", 32'(state_out), 32'd0);
    expect_eq("mid.strb", 32'(strb), 32'd0);
    expect_eq("mid.retired", retired, 32'd0);

    // Two ADDIs then HALT
    do_reset("halt");
    start = 1'b1; imem_valid = 1'b1; reg_we = 1'b1;
    cyc("halt.if", 3'd1, V_IF);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc("halt.id", 3'd2, V_ID);
      cyc("halt.ex", 3'd3, V_EX);
      cyc("halt.wb", 3'd5, V_WB_RF);
      cyc("halt.if", 3'd1, V_IF);
    end
    cyc("halt.id3", 3'd2, V_ID);
    is_halt = 1'b1;
    cyc("halt.ex3", 3'd3, V_EX);
    cyc("halt.h", 3'd6, V_NONE);
    expect_eq("halt.halted", 32'(halted), 32'd1);
    expect_eq("halt.retired", retired, 32'd2);
    start = 1'b1;
    cyc("halt.h2", 3'd6, V_NONE);
    start = 1'b0;
    cyc("halt.h3", 3'd6, V_NONE);
    expect_eq("halt.retired2", retired, 32'd2);
    expect_eq("halt.err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
